// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II M-stage multiply sequencer.
//   - operand/half-word widths
//   - op encodings carried on in_op
//   - sequencer state codes
//   - op decode helpers (is high-word op, operand signedness)
package nios2_mul_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ISSUE1 = 3'd1;
  localparam state_t S_WAIT1  = 3'd2;
  localparam state_t S_CAPT1  = 3'd3;
  localparam state_t S_ISSUE2 = 3'd4;
  localparam state_t S_WAIT2  = 3'd5;
  localparam state_t S_CAPT2  = 3'd6;
  localparam state_t S_DONE   = 3'd7;

  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == OP_MULXSU) || (op == OP_MULXSS);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == OP_MULXSS);
  endfunction

  function automatic logic op_is_mulx(input logic [1:0] op);
    return (op == OP_MULXUU) || op_a_signed(op);
  endfunction

endpackage

// File: rtl/nios2_mul_combine.sv
// Partial-product combiner (purely combinational).
//   mode=0 (first pass):  word = low 32 bits of p1 + (p2+p3)<<16,
//                         mid_hi_nx / carry_nx = bits to carry into the high word.
//   mode=1 (second pass): word = high 32 bits, p1 being a[31:16]*b[31:16],
//                         with mid_hi / carry from the first pass and the
//                         two's-complement correction for signed operands.
// Ports:
//   mode      in   pass select
//   op        in   op code (signedness)
//   a, b      in   full operands (signed correction terms)
//   p1..p3    in   cell partial products
//   mid_hi    in   registered (p2+p3)[32:16]
//   carry     in   registered carry-out of the low word
//   word      out  assembled 32-bit word
//   mid_hi_nx out  (p2+p3)[32:16] of the current pass
//   carry_nx  out  carry-out of the current low-word sum
module nios2_mul_combine
  import nios2_mul_pkg::*;
(
  input  logic              mode,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] p1,
  input  logic [WORD_W-1:0] p2,
  input  logic [WORD_W-1:0] p3,
  input  logic [HALF_W:0]   mid_hi,
  input  logic              carry,
  output logic [WORD_W-1:0] word,
  output logic [HALF_W:0]   mid_hi_nx,
  output logic              carry_nx
);

  logic [WORD_W:0]   mid;
  logic [WORD_W:0]   lo_sum;
  logic [WORD_W-1:0] hi;

  always_comb begin
    mid    = {1'b0, p2} + {1'b0, p3};
    lo_sum = {1'b0, p1} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};

    // Unsigned high word, then subtract the other operand once per negative
    // signed operand: a_s = a_u - 2^32*a[31], so the high word loses b (and a).
    hi = p1 + {{(WORD_W-HALF_W-1){1'b0}}, mid_hi} + {{(WORD_W-1){1'b0}}, carry};
    if (op_a_signed(op) && a[WORD_W-1]) hi = hi - b;
    if (op_b_signed(op) && b[WORD_W-1]) hi = hi - a;

    mid_hi_nx = mid[WORD_W:HALF_W];
    carry_nx  = lo_sum[WORD_W];
    word      = mode ? hi : lo_sum[WORD_W-1:0];
  end

endmodule

// File: rtl/nios2_mul_seq.sv
// Multiply sequencer for the Nios II M-stage 16x16 three-product cell.
// Issues operand pairs to the cell, captures p1..p3 and assembles the low
// word (MUL) or, with a second cell pass, the high word (MULXUU/SU/SS).
// Build option: NIOS2_MULX_EN -- when defined the high-word ops are built;
// otherwise a MULX* op finishes at MUL latency with result=0, result_err=1.
// Parameters:
//   CELL_LAT  cycles from cell_en to valid products (1..3)
//   OUT_REG   1: result registered in DONE; 0: result driven from capture state
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready/in_op/in_src*   issue handshake and operands
//   flush                             synchronous abort
//   cell_src1/cell_src2/cell_en       to multiplier cell
//   cell_p1..cell_p3                  partial products from cell
//   result_valid/result_ready         result handshake
//   result/result_err                 product word, unsupported-op flag
//
// state  | meaning
// IDLE   | waiting for a request, in_ready=1
// ISSUE1 | drive A,B to the cell, cell_en=1
// WAIT1  | wait out remaining cell latency
// CAPT1  | combine p1..p3 into low word / carries
// ISSUE2 | drive A[31:16],B[31:16] to the cell
// WAIT2  | wait out remaining cell latency
// CAPT2  | assemble high word with signed correction
// DONE   | result_valid=1, hold until result_ready
module nios2_mul_seq
  import nios2_mul_pkg::*;
#(
  parameter int CELL_LAT = 1,
  parameter int OUT_REG  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [WORD_W-1:0] in_src1,
  input  logic [WORD_W-1:0] in_src2,
  input  logic              flush,
  output logic [WORD_W-1:0] cell_src1,
  output logic [WORD_W-1:0] cell_src2,
  output logic              cell_en,
  input  logic [WORD_W-1:0] cell_p1,
  input  logic [WORD_W-1:0] cell_p2,
  input  logic [WORD_W-1:0] cell_p3,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [WORD_W-1:0] result,
  output logic              result_err
);

`ifdef NIOS2_MULX_EN
  localparam bit MULX_BUILT = 1'b1;
`else
  localparam bit MULX_BUILT = 1'b0;
`endif

  // Down-counter start for the WAIT states; WAIT is skipped when CELL_LAT=1.
  localparam logic [1:0] WAIT_INIT = (CELL_LAT > 1) ? 2'(CELL_LAT - 2) : 2'd0;

  state_t            state_q, state_nx;
  logic [WORD_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic [1:0]        cnt_q;
  logic [HALF_W:0]   mid_hi_q;
  logic              carry_q;

  logic [WORD_W-1:0] comb_word;
  logic [HALF_W:0]   comb_mid_hi;
  logic              comb_carry;

  logic              accept;
  logic              capt1_last;
  logic              capt_last;
  logic              err_now;
  logic [WORD_W-1:0] cap_word;

  assign accept     = (state_q == S_IDLE) && in_valid && !flush;
  assign capt1_last = (state_q == S_CAPT1) && (!MULX_BUILT || !op_is_mulx(op_q));
  assign capt_last  = capt1_last || (state_q == S_CAPT2);
  assign err_now    = !MULX_BUILT && op_is_mulx(op_q);
  assign cap_word   = err_now ? '0 : comb_word;

  assign in_ready = (state_q == S_IDLE);
  assign cell_en  = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);

  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    if (state_q == S_ISSUE1) begin
      cell_src1 = a_q;
      cell_src2 = b_q;
    end else if (state_q == S_ISSUE2) begin
      cell_src1 = {{HALF_W{1'b0}}, a_q[WORD_W-1:HALF_W]};
      cell_src2 = {{HALF_W{1'b0}}, b_q[WORD_W-1:HALF_W]};
    end
  end

  nios2_mul_combine u_combine (
    .mode      (state_q == S_CAPT2),
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .p1        (cell_p1),
    .p2        (cell_p2),
    .p3        (cell_p3),
    .mid_hi    (mid_hi_q),
    .carry     (carry_q),
    .word      (comb_word),
    .mid_hi_nx (comb_mid_hi),
    .carry_nx  (comb_carry)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_nx = S_ISSUE1;
      S_ISSUE1: state_nx = (CELL_LAT > 1) ? S_WAIT1 : S_CAPT1;
      S_WAIT1:  if (cnt_q == 2'd0) state_nx = S_CAPT1;
      S_CAPT1: begin
`ifdef NIOS2_MULX_EN
        if (op_is_mulx(op_q)) state_nx = S_ISSUE2;
        else
`endif
        if (OUT_REG != 0) state_nx = S_DONE;
        else if (result_ready) state_nx = S_IDLE;
      end
`ifdef NIOS2_MULX_EN
      S_ISSUE2: state_nx = (CELL_LAT > 1) ? S_WAIT2 : S_CAPT2;
      S_WAIT2:  if (cnt_q == 2'd0) state_nx = S_CAPT2;
      S_CAPT2: begin
        if (OUT_REG != 0) state_nx = S_DONE;
        else if (result_ready) state_nx = S_IDLE;
      end
`endif
      S_DONE:   if (result_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    // Abort beats everything, including a same-cycle DONE consume.
    if (flush && (state_q != S_IDLE)) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_MUL;
      cnt_q    <= 2'd0;
      mid_hi_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        a_q  <= in_src1;
        b_q  <= in_src2;
        op_q <= in_op;
      end
      if ((state_q == S_ISSUE1) || (state_q == S_ISSUE2)) begin
        cnt_q <= WAIT_INIT;
      end else if (((state_q == S_WAIT1) || (state_q == S_WAIT2)) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state_q == S_CAPT1) begin
        mid_hi_q <= comb_mid_hi;
        carry_q  <= comb_carry;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WORD_W-1:0] result_q;
      logic              err_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          result_q <= '0;
          err_q    <= 1'b0;
        end else if ((state_nx == S_DONE) && (state_q != S_DONE)) begin
          result_q <= cap_word;
          err_q    <= err_now;
        end else if ((state_q == S_DONE) && (state_nx != S_DONE)) begin
          result_q <= '0;
          err_q    <= 1'b0;
        end
      end

      assign result_valid = (state_q == S_DONE);
      assign result       = result_q;
      assign result_err   = err_q;
    end else begin : g_out_comb
      // Cell outputs and mid/carry registers hold while waiting for ready.
      assign result_valid = capt_last;
      assign result       = capt_last ? cap_word : '0;
      assign result_err   = capt_last && err_now;
    end
  endgenerate

endmodule

// File: tb/tb_nios2_mul_seq.sv
module tb_nios2_mul_seq;

`ifdef NIOS2_MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic        flush;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        result_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] corners [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};

  nios2_mul_seq #(.CELL_LAT(1), .OUT_REG(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .flush        (flush),
    .cell_src1    (cell_src1),
    .cell_src2    (cell_src2),
    .cell_en      (cell_en),
    .cell_p1      (cell_p1),
    .cell_p2      (cell_p2),
    .cell_p3      (cell_p3),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_err   (result_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-product 16x16 cell, one-cycle latency, holds while cell_en is low.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // {err, word}: full 64-bit product with the op's signedness.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, pr;
    sa = (op >= 2'd2 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    sb = (op == 2'd3 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    pr = sa * sb;
    if (op == 2'd0) return {1'b0, pr[31:0]};
    if (MULX) return {1'b0, pr[63:32]};
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 6)];
    return $urandom;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_src1  = $urandom;
    in_src2  = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit ready_early);
    logic [32:0] m;
    logic [7:0]  en_mask, exp_mask;
    logic [31:0] s1a, s2a, s1b, s2b, r0;
    int          n, exp_lat;
    bit          got;
    bit          two_pass;
    m        = model(op, a, b);
    two_pass = MULX && (op != 2'd0);
    exp_lat  = two_pass ? 5 : 3;
    exp_mask = two_pass ? 8'b0000_1010 : 8'b0000_0010;
    en_mask  = '0;
    s1a = '0; s2a = '0; s1b = '0; s2b = '0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    result_ready = ready_early;
    start_op(op, a, b);
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (cell_en && n < 8) begin
        en_mask[n] = 1'b1;
        if (n == 1) begin s1a = cell_src1; s2a = cell_src2; end
        else begin s1b = cell_src1; s2b = cell_src2; end
      end
      if (result_valid) got = 1;
    end
    check("valid_seen", got, 1);
    check("latency", n, exp_lat);
    check("result", result, m[31:0]);
    check("result_err", result_err, m[32]);
    check("cell_en_pulses", en_mask, exp_mask);
    check("pass1_src1", s1a, a);
    check("pass1_src2", s2a, b);
`ifdef NIOS2_MULX_EN
    if (op != 2'd0) begin
      check("pass2_src1", s1b, {16'h0, a[31:16]});
      check("pass2_src2", s2b, {16'h0, b[31:16]});
    end
`endif
    r0 = result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_result", result, r0);
      check("hold_in_ready", in_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    check("consumed_valid", result_valid, 0);
    check("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [1:0] rop;
    int         hold, n;
    bit         early;

    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_op        = 2'd0;
    in_src1      = '0;
    in_src2      = '0;
    flush        = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_cell_en", cell_en, 0);
    check("rst_cell_src1", cell_src1, 0);
    check("rst_cell_src2", cell_src2, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_err", result_err, 0);
    reset_n = 1'b1;

    // Directed vectors.
    run_op(2'd0, 32'h0001_2345, 32'h0001_0001, 0, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'h0000_0002, 0, 0);
    run_op(2'd1, 32'h8000_0000, 32'h0000_0002, 0, 0);
    run_op(2'd1, 32'd3, 32'd5, 0, 0);
    run_op(2'd0, 32'd3, 32'd5, 0, 0);

    // Backpressure and early ready.
    run_op(2'd3, pick(), pick(), 4, 0);
    run_op(2'd0, pick(), pick(), 0, 1);

    // Randomized ops against the model.
    for (int i = 0; i < 30; i++) begin
      rop   = 2'($urandom_range(0, 3));
      hold  = $urandom_range(0, 2);
      early = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(rop, pick(), pick(), hold, early);
    end

    // flush in CAPT1: no result, back to IDLE.
    start_op(2'd1, pick(), pick());
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_capt_valid", result_valid, 0);
      check("flush_capt_cell_en", cell_en, 0);
      check("flush_capt_in_ready", in_ready, 1);
    end

    // flush with in_valid in IDLE: not accepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_src1  = 32'd7;
    in_src2  = 32'd9;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_idle_cell_en", cell_en, 0);
      check("flush_idle_in_ready", in_ready, 1);
      check("flush_idle_valid", result_valid, 0);
    end

    // flush together with DONE & result_ready.
    start_op(2'd0, pick(), pick());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 20);
    check("flushdone_reach", result_valid, 1);
    flush        = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    check("flushdone_valid", result_valid, 0);
    check("flushdone_in_ready", in_ready, 1);
    run_op(2'd0, 32'd6, 32'd7, 0, 0);

    // Asynchronous reset in the middle of a high-word op.
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_cell_en", cell_en, 0);
    check("arst_cell_src1", cell_src1, 0);
    check("arst_cell_src2", cell_src2, 0);
    check("arst_valid", result_valid, 0);
    check("arst_result", result, 0);
    check("arst_err", result_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(2'd3, pick(), pick(), 1, 0);
    run_op(2'd0, pick(), pick(), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
